// File: rtl/ysyx_25020047_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_25020047_seq_ctrl
// Description : Multi-cycle instruction sequencer for the NPC core. Schedules
//               fetch, decode, memory access and writeback, drives the IFU/LSU
//               request handshakes and gates GPR/PC write enables.
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_25020047_seq_ctrl #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] i_inst_type,
   input  logic        i_ifu_rvalid,
   input  logic        i_lsu_rvalid,
   output logic        o_ifu_req,
   output logic        o_inst_en,
   output logic        o_lsu_req,
   output logic        o_lsu_wen,
   output logic        o_reg_wen,
   output logic        o_pc_wen,
   output logic        o_halt,
   output logic        o_err,
   output logic [31:0] o_inst_cnt
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5,
      S_ERR    = 3'd6
   } state_t;

   // The wait counter starts at 0 on entry, so the last cycle allowed to
   // wait is the one where it holds TIMEOUT-1.
   localparam logic [15:0] c_TMO_LAST = 16'(TIMEOUT - 32'd1);
   localparam logic [31:0] c_EBREAK   = 32'h0000_0004;
   localparam logic [31:0] c_LB       = 32'h0000_0020;
   localparam logic [31:0] c_LW       = 32'h0000_0040;
   localparam logic [31:0] c_SB       = 32'h0000_0080;
   localparam logic [31:0] c_SW       = 32'h0000_0100;
   localparam logic [31:0] c_SH       = 32'h0020_0000;
   localparam logic [31:0] c_BEQ      = 32'h0000_4000;
   localparam logic [31:0] c_BNE      = 32'h0000_8000;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [15:0] r_tmo;
   logic        r_is_load;
   logic        r_is_store;
   logic        r_writes_rd;
   logic [31:0] r_inst_cnt;

   logic        w_onehot;
   logic        w_dec_load;
   logic        w_dec_store;
   logic        w_dec_wrd;
   logic        w_tmo_hit;
   logic        w_retire;

   // Decoder class of the code presented in DECODE; only latched there.
   assign w_onehot    = (i_inst_type != 32'd0) &&
                        ((i_inst_type & (i_inst_type - 32'd1)) == 32'd0);
   assign w_dec_load  = (i_inst_type == c_LB) || (i_inst_type == c_LW);
   assign w_dec_store = (i_inst_type == c_SB) || (i_inst_type == c_SW) ||
                        (i_inst_type == c_SH);
   assign w_dec_wrd   = !w_dec_store && (i_inst_type != c_BEQ) &&
                        (i_inst_type != c_BNE);
   assign w_tmo_hit   = (r_tmo == c_TMO_LAST);

   // ebreak retires on the DECODE->HALT edge; everything else in WB.
   assign w_retire    = (r_state == S_WB) ||
                        ((r_state == S_DECODE) && (w_state_nxt == S_HALT));

   assign o_inst_cnt  = r_inst_cnt;

   // Next-state and output decode; a bus response beats a same-cycle timeout.
   always_comb begin
      w_state_nxt = r_state;
      o_ifu_req   = 1'b0;
      o_inst_en   = 1'b0;
      o_lsu_req   = 1'b0;
      o_lsu_wen   = 1'b0;
      o_reg_wen   = 1'b0;
      o_pc_wen    = 1'b0;
      o_halt      = 1'b0;
      o_err       = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_state_nxt = S_FETCH;
         end
         S_FETCH: begin
            o_ifu_req = 1'b1;
            if (i_ifu_rvalid) begin
               o_inst_en   = 1'b1;
               w_state_nxt = S_DECODE;
            end else if (w_tmo_hit) begin
               w_state_nxt = S_ERR;
            end
         end
         S_DECODE: begin
            if (i_inst_type == c_EBREAK) begin
               w_state_nxt = S_HALT;
            end else if (!w_onehot) begin
               w_state_nxt = S_ERR;
            end else if (w_dec_load || w_dec_store) begin
               w_state_nxt = S_MEM;
            end else begin
               w_state_nxt = S_WB;
            end
         end
         S_MEM: begin
            o_lsu_req = 1'b1;
            // A code is never both load and store; the guard keeps a
            // corrupted class from issuing a write.
            o_lsu_wen = r_is_store && !r_is_load;
            if (i_lsu_rvalid) begin
               w_state_nxt = S_WB;
            end else if (w_tmo_hit) begin
               w_state_nxt = S_ERR;
            end
         end
         S_WB: begin
            o_reg_wen   = r_writes_rd;
            o_pc_wen    = 1'b1;
            w_state_nxt = S_FETCH;
         end
         S_HALT: begin
            o_halt = 1'b1;
         end
         S_ERR: begin
            o_err = 1'b1;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Bus wait counter: zeroed on any state change, counts while waiting.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_tmo <= 16'd0;
      end else if (r_state != w_state_nxt) begin
         r_tmo <= 16'd0;
      end else if ((r_state == S_FETCH) || (r_state == S_MEM)) begin
         r_tmo <= r_tmo + 16'd1;
      end
   end

   // Instruction class captured in DECODE for use in MEM and WB.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_is_load   <= 1'b0;
         r_is_store  <= 1'b0;
         r_writes_rd <= 1'b0;
      end else if (r_state == S_DECODE) begin
         r_is_load   <= w_dec_load;
         r_is_store  <= w_dec_store;
         r_writes_rd <= w_dec_wrd;
      end
   end

   // Retired-instruction counter, wraps modulo 2^32.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_inst_cnt <= 32'd0;
      end else if (w_retire) begin
         r_inst_cnt <= r_inst_cnt + 32'd1;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_25020047_seq_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_ysyx_25020047_seq_ctrl
// Description : Scoreboard bench for the instruction sequencer. A responder
//               answers IFU/LSU requests from a stimulus queue; a monitor
//               matches observed retire/halt/error events to expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ysyx_25020047_seq_ctrl;

   localparam int unsigned TMO = 4;
   localparam int K_RET  = 0;
   localparam int K_HALT = 1;
   localparam int K_ERR  = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] i_inst_type = 32'd0;
   logic        i_ifu_rvalid = 1'b0;
   logic        i_lsu_rvalid = 1'b0;
   logic        o_ifu_req, o_inst_en, o_lsu_req, o_lsu_wen;
   logic        o_reg_wen, o_pc_wen, o_halt, o_err;
   logic [31:0] o_inst_cnt;

   always #5 clk = ~clk;

   ysyx_25020047_seq_ctrl #(.TIMEOUT(TMO)) dut (
      .clk          (clk),
      .rst          (rst),
      .i_inst_type  (i_inst_type),
      .i_ifu_rvalid (i_ifu_rvalid),
      .i_lsu_rvalid (i_lsu_rvalid),
      .o_ifu_req    (o_ifu_req),
      .o_inst_en    (o_inst_en),
      .o_lsu_req    (o_lsu_req),
      .o_lsu_wen    (o_lsu_wen),
      .o_reg_wen    (o_reg_wen),
      .o_pc_wen     (o_pc_wen),
      .o_halt       (o_halt),
      .o_err        (o_err),
      .o_inst_cnt   (o_inst_cnt)
   );

   typedef struct {
      logic [31:0] code;
      int          iw;   // fetch wait cycles
      int          lw;   // memory wait cycles
   } stim_t;

   typedef struct {
      int          kind;
      logic        reg_wen;
      logic        mem;
      logic        lsu_wen;
      int          mcyc;  // cycles with lsu_req high
      int          cyc;   // cycle (from first fetch cycle) of the final event
      logic [31:0] cnt;   // inst_cnt after the event
   } exp_t;

   stim_t       stq[$];
   exp_t        sb[$];
   int          errors = 0;
   int          checks = 0;
   logic [31:0] model_cnt = 32'd0;
   bit          pend = 1'b0;
   logic [31:0] pend_val = 32'd0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%08h, required 0x%08h at %0t", nm, act, req, $time);
      end
   endtask

   // Reference model: derive the expected outcome from the instruction rules.
   task automatic issue(input logic [31:0] code, input int iw, input int lw);
      stim_t s;
      exp_t  e;
      bit    ld, st, mem;
      s.code = code; s.iw = iw; s.lw = lw;
      stq.push_back(s);
      ld  = (code == 32'h20) || (code == 32'h40);
      st  = (code == 32'h80) || (code == 32'h100) || (code == 32'h200000);
      mem = ld || st;
      e.kind = K_RET; e.reg_wen = 1'b0; e.mem = 1'b0; e.lsu_wen = 1'b0; e.mcyc = 0;
      if (iw >= int'(TMO)) begin
         e.kind = K_ERR;  e.cyc = int'(TMO) + 1;
      end else if (code == 32'h4) begin
         model_cnt = model_cnt + 32'd1;
         e.kind = K_HALT; e.cyc = iw + 3;
      end else if ($countones(code) != 1) begin
         e.kind = K_ERR;  e.cyc = iw + 3;
      end else if (mem && lw >= int'(TMO)) begin
         e.kind = K_ERR;  e.cyc = iw + int'(TMO) + 3;
      end else begin
         model_cnt = model_cnt + 32'd1;
         e.reg_wen = !st && (code != 32'h4000) && (code != 32'h8000);
         e.mem     = mem;
         e.lsu_wen = st;
         e.mcyc    = mem ? lw + 1 : 0;
         e.cyc     = iw + 3 + e.mcyc;
      end
      e.cnt = model_cnt;
      sb.push_back(e);
   endtask

   // Bus responder: answers each request after the stimulus-chosen delay,
   // presents inst_type only around DECODE and drives stray responses elsewhere.
   initial begin
      stim_t cur;
      bit    f_act = 1'b0;
      int    fcnt = 0, lcnt = 0, hold = 0;
      cur.code = 32'd0; cur.iw = 0; cur.lw = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            f_act = 1'b0; hold = 0;
            i_ifu_rvalid = 1'b0; i_lsu_rvalid = 1'b0;
            continue;
         end
         if (hold > 0) hold--;
         else i_inst_type = $urandom;
         if (o_ifu_req) begin
            if (!f_act && stq.size() > 0) begin
               cur = stq.pop_front(); f_act = 1'b1; fcnt = cur.iw;
            end
            if (f_act && fcnt == 0) begin
               i_ifu_rvalid = 1'b1; i_inst_type = cur.code; hold = 2;
               f_act = 1'b0; lcnt = cur.lw;
            end else begin
               i_ifu_rvalid = 1'b0;
               if (f_act) fcnt--;
            end
         end else begin
            i_ifu_rvalid = 1'($urandom_range(0, 1));
         end
         if (o_lsu_req) begin
            if (lcnt == 0) i_lsu_rvalid = 1'b1;
            else begin i_lsu_rvalid = 1'b0; lcnt--; end
         end else begin
            i_lsu_rvalid = 1'($urandom_range(0, 1));
         end
      end
   end

   // Monitor: protocol checks each cycle and scoreboard match on each event.
   initial begin
      exp_t e;
      bit   act = 1'b0, saw_mem = 1'b0, saw_wen = 1'b0;
      bit   prev_ifu = 1'b0, prev_halt = 1'b0, prev_err = 1'b0, bad;
      int   cyc = 0, mcyc = 0;
      forever begin
         @(negedge clk); #1;
         if (rst) begin
            act = 1'b0; pend = 1'b0;
            prev_ifu = 1'b0; prev_halt = 1'b0; prev_err = 1'b0;
            continue;
         end
         if (pend) begin
            chk("inst_cnt_after_wb", o_inst_cnt, pend_val);
            pend = 1'b0;
         end
         if (o_ifu_req && !prev_ifu) begin
            act = 1'b1; cyc = 1; mcyc = 0; saw_mem = 1'b0; saw_wen = 1'b0;
         end else if (act) begin
            cyc++;
         end
         if (o_lsu_req) begin saw_mem = 1'b1; mcyc++; end
         if (o_lsu_wen) saw_wen = 1'b1;
         bad = (o_inst_en && !o_ifu_req) || (o_reg_wen && !o_pc_wen) ||
               (o_lsu_wen && !o_lsu_req) || (o_ifu_req && o_lsu_req) ||
               (o_halt && o_err) || (prev_halt && !o_halt) || (prev_err && !o_err) ||
               ((o_halt || o_err) &&
                (o_ifu_req || o_lsu_req || o_pc_wen || o_reg_wen || o_inst_en));
         chk("protocol", 32'(bad), 32'd0);
         if (o_pc_wen || (o_halt && !prev_halt) || (o_err && !prev_err)) begin
            if (sb.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_event: got pc_wen=%0b halt=%0b err=%0b, required no event",
                        o_pc_wen, o_halt, o_err);
            end else begin
               e = sb.pop_front();
               chk("event_kind", o_pc_wen ? K_RET : (o_halt ? K_HALT : K_ERR), e.kind);
               chk("event_cycle", cyc, e.cyc);
               if (o_pc_wen) begin
                  chk("reg_wen", 32'(o_reg_wen), 32'(e.reg_wen));
                  chk("mem_used", 32'(saw_mem), 32'(e.mem));
                  chk("lsu_wen", 32'(saw_wen), 32'(e.lsu_wen));
                  chk("mem_cycles", mcyc, e.mcyc);
                  pend = 1'b1; pend_val = e.cnt;
               end else begin
                  chk("inst_cnt_at_stop", o_inst_cnt, e.cnt);
               end
            end
            act = 1'b0;
         end
         prev_ifu = o_ifu_req; prev_halt = o_halt; prev_err = o_err;
      end
   end

   task automatic reset_begin();
      @(negedge clk);
      rst = 1'b1;
      stq.delete(); sb.delete();
      model_cnt = 32'd0;
      repeat (2) @(posedge clk);
   endtask

   task automatic reset_end();
      @(negedge clk); #2;
      chk("reset_outputs",
          32'({o_ifu_req, o_inst_en, o_lsu_req, o_lsu_wen, o_reg_wen, o_pc_wen, o_halt, o_err}),
          32'd0);
      chk("reset_inst_cnt", o_inst_cnt, 32'd0);
      rst = 1'b0;
      @(negedge clk); #2;
      chk("first_ifu_req", 32'(o_ifu_req), 32'd1);
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while ((sb.size() != 0 || pend) && n < budget) begin
         @(negedge clk); #2;
         n++;
      end
      if (sb.size() != 0 || pend) begin
         checks++; errors++;
         $display("FAIL drain_timeout: got %0d pending expectations, required 0", sb.size());
      end
   endtask

   logic [31:0] codes [13] = '{32'h1, 32'h2, 32'h8, 32'h10, 32'h20, 32'h40, 32'h80,
                               32'h100, 32'h200000, 32'h4000, 32'h8000, 32'h400, 32'h80000000};

   initial begin
      logic [31:0] c;
      // addi, zero-wait
      reset_begin(); issue(32'h1, 0, 0); reset_end(); drain(50);
      // sw with 3 LSU wait cycles
      reset_begin(); issue(32'h80, 0, 3); reset_end(); drain(50);
      // lw then beq
      reset_begin(); issue(32'h20, 0, 0); issue(32'h4000, 0, 0); reset_end(); drain(50);
      // addi then ebreak, hold HALT
      reset_begin(); issue(32'h1, 1, 0); issue(32'h4, 0, 0); reset_end(); drain(50);
      repeat (22) @(negedge clk);
      #2;
      chk("halt_held", 32'(o_halt), 32'd1);
      chk("halt_no_fetch", 32'(o_ifu_req), 32'd0);
      chk("halt_inst_cnt", o_inst_cnt, 32'd2);
      // IFU silent past the timeout
      reset_begin(); issue(32'h1, 4, 0); reset_end(); drain(50);
      // IFU answers on the last allowed cycle, then LSU times out
      reset_begin(); issue(32'h1, 3, 0); issue(32'h100, 0, 4); reset_end(); drain(50);
      // illegal codes
      reset_begin(); issue(32'h1, 0, 0); issue(32'hFFFF_FFFF, 0, 0); reset_end(); drain(50);
      reset_begin(); issue(32'h3, 2, 0); reset_end(); drain(50);
      reset_begin(); issue(32'h0, 0, 0); reset_end(); drain(50);
      // reset in the middle of a store
      reset_begin(); issue(32'h80, 0, 3); reset_end();
      repeat (3) @(negedge clk);
      // counter wrap
      reset_begin(); model_cnt = 32'hFFFF_FFFF; issue(32'h1, 3, 0); reset_end();
      force dut.r_inst_cnt = 32'hFFFF_FFFF;
      @(negedge clk); #2;
      chk("forced_inst_cnt", o_inst_cnt, 32'hFFFF_FFFF);
      release dut.r_inst_cnt;
      drain(50);
      // random legal stream
      reset_begin();
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            c = 32'h1 << $urandom_range(0, 31);
            if (c == 32'h4) c = 32'h1;
         end else begin
            c = codes[$urandom_range(0, 12)];
         end
         issue(c, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      end
      reset_end(); drain(1000);
      reset_begin();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no completion, required finish before time limit");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire

// File: doc/ysyx_25020047_seq_ctrl.md
# ysyx_25020047_seq_ctrl

Multi-cycle sequencer for the NPC core: it owns the per-instruction schedule of fetch, decode, memory access and register/PC writeback. It drives the request side of the IFU and LSU bus handshakes, latches the fetched instruction into the decoder, and gates the GPR write enable (`reg_wen`) and PC update (`dnpc` commit) that the decode stage otherwise applies every cycle. It sits between the IFU/LSU bus ports and the IDU/GPR/PC datapath, and consumes the decoder's one-hot `inst_type` code.

## Interface
- `TIMEOUT`, 255: maximum cycles to wait for a bus response before entering ERR; legal range 1..65535.
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `inst_type`  in  32  one-hot decode code from the IDU; valid only in DECODE. Special codes: `0x4` ebreak, `0xFFFFFFFF` illegal.
- `ifu_rvalid`  in  1  instruction fetch response valid.
- `lsu_rvalid`  in  1  load/store completion valid.
- `ifu_req`  out  1  fetch request; held high until `ifu_rvalid`.
- `inst_en`  out  1  instruction register load strobe.
- `lsu_req`  out  1  memory request; held high until `lsu_rvalid`.
- `lsu_wen`  out  1  memory request is a store.
- `reg_wen`  out  1  GPR write enable, one-cycle pulse.
- `pc_wen`  out  1  PC update enable (`pc <= dnpc`), one-cycle pulse.
- `halt`  out  1  sticky; ebreak retired.
- `err`  out  1  sticky; illegal instruction or bus timeout.
- `inst_cnt`  out  32  retired-instruction counter.

## Operation
- States: IDLE, FETCH, DECODE, MEM, WB, HALT, ERR. All outputs are combinational decodes of the state and inputs. No output depends combinationally on `inst_type` outside DECODE and the MEM/WB states, which use a class latched at DECODE.
- IDLE: this is the reset state. It moves to FETCH unconditionally on the next edge. All outputs are 0.
- FETCH:
  - `ifu_req`=1.
  - When `ifu_rvalid`=1: `inst_en`=1 in the same cycle, then go to DECODE.
- DECODE: one cycle. Latch the class register {is_load, is_store, writes_rd}, then branch:
  - `0x4` → HALT.
  - `0xFFFFFFFF` or any non-one-hot value → ERR.
  - Loads (`0x20`, `0x40`) → MEM.
  - Stores (`0x80`, `0x100`, `0x200000`) → MEM.
  - Everything else → WB.
- writes_rd classification: 0 for stores, `0x4000` (beq) and `0x8000` (bne); 1 for all other legal codes.
- MEM:
  - `lsu_req`=1; `lsu_wen`=is_store.
  - When `lsu_rvalid`=1, go to WB.
- WB: one cycle.
  - `reg_wen`=writes_rd; `pc_wen`=1.
  - `inst_cnt` increments by 1, modulo 2^32 (0xFFFFFFFF wraps to 0).
  - Then go to FETCH.
- HALT: `halt`=1 and no requests. Stays here until `rst`. `inst_cnt` is incremented once on the DECODE→HALT edge, because ebreak counts as retired. `pc_wen` is not asserted.
- ERR: `err`=1 and no requests. Stays here until `rst`. `inst_cnt` does not increment.
- Timeout counter:
  - 16 bits; cleared on every entry to FETCH or MEM; increments each cycle spent waiting in FETCH or MEM.
  - If the counter reaches `TIMEOUT` with no response, go to ERR.
  - If a response arrives in the same cycle the counter reaches `TIMEOUT`, the response wins.
- Stray responses: `ifu_rvalid` outside FETCH and `lsu_rvalid` outside MEM are ignored.

## Timing
- Reset values (registered in the `rst` cycle): state=IDLE, `inst_cnt`=0, timeout counter=0. Consequently `ifu_req`, `inst_en`, `lsu_req`, `lsu_wen`, `reg_wen`, `pc_wen`, `halt` and `err` are all 0.
- Reset mid-operation (any state, including HALT/ERR): the next edge returns to IDLE with all outputs cleared. A pending bus request is dropped with no completion.
- Zero-wait bus (response in the same cycle as the request):
  - ALU/branch/jump instruction: FETCH, DECODE, WB = 3 cycles.
  - Load/store: FETCH, DECODE, MEM, WB = 4 cycles.
- Each wait cycle on a bus adds one cycle to that instruction.
- `reg_wen` and `pc_wen` are asserted in exactly one cycle per retired instruction and never outside WB.
- `inst_en` is high for exactly one cycle per fetch.
- From reset release to the first `ifu_req`: 1 cycle (IDLE).

## Test plan
- Reset, then addi (`inst_type`=`0x1`) with zero-wait IFU: `ifu_req` rises 1 cycle after reset release, `inst_en` pulses the same cycle. WB 2 cycles later shows `reg_wen`=1, `pc_wen`=1. `inst_cnt`=1.
- sw (`0x80`) with LSU response after 3 wait cycles: `lsu_req`=`lsu_wen`=1 for 4 cycles. WB then shows `reg_wen`=0, `pc_wen`=1.
- lw (`0x20`) followed by beq (`0x4000`): the lw has `reg_wen`=1 with `lsu_wen`=0 and takes 4 cycles. The beq has `reg_wen`=0 and `pc_wen`=1 and takes 3 cycles. `inst_cnt`=2.
- ebreak (`0x4`): HALT is entered and `halt`=1 is held for 20+ cycles. `ifu_req` stays 0 and `inst_cnt` increments by 1. Asserting `rst` then returns the block to IDLE with `halt`=0.
- `TIMEOUT`=4 with the IFU silent: `err`=1 on the 5th fetch cycle. Repeat with `ifu_rvalid` arriving on the 4th wait cycle: `inst_en`=1 and no error.
- Preload `inst_cnt` to 0xFFFFFFFF via a force, then retire one addi: `inst_cnt`=0. Separately, `inst_type`=`0xFFFFFFFF` → `err`=1 with no `reg_wen`.
